// File: rtl/mc_datapath_pkg.sv
// -----------------------------------------------------------------------------
// mc_datapath_pkg
// Shared definitions for the multicycle RV32I datapath: control-select
// encodings, ALU function codes, base opcodes, datapath width and the
// immediate extender helper.
// -----------------------------------------------------------------------------
package mc_datapath_pkg;

    localparam int XLEN = 32;

    // Result mux select
    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_ALURES_B  = 2'b11
    } result_src_e;

    // Operand A select
    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    // Operand B select
    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } src_b_e;

    // Immediate format
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // ALU function; unlisted codes produce zero
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // Base opcodes decoded by the controller
    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_JAL = 7'd111;

    // Sign-extended immediate; the sign bit is instr[31] for every format.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                               input logic [1:0]  imm_src);
        logic [31:0] imm;
        case (imm_src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// -----------------------------------------------------------------------------
// mc_regfile
// Register file with two asynchronous read ports and one synchronous write
// port. Entry 0 is hardwired to zero, so writes to x0 vanish. All entries
// clear on the asynchronous reset, which rules out a block-RAM mapping.
// Reads return the stored value; a same-cycle write is not bypassed.
//
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   ra1, ra2     read addresses
//   rd1, rd2     read data
//   we, wa, wd   write enable, address, data
// -----------------------------------------------------------------------------
module mc_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [$clog2(NREGS)-1:0] ra1,
    input  logic [$clog2(NREGS)-1:0] ra2,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wa,
    input  logic [XLEN-1:0]          wd
);
    import mc_datapath_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] rf_q;

    assign rf_q[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_entry
            logic [XLEN-1:0] q_reg;

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    q_reg <= '0;
                end else if (we && (wa == AW'(gi))) begin
                    q_reg <= wd;
                end
            end

            assign rf_q[gi] = q_reg;
        end
    endgenerate

    assign rd1 = rf_q[ra1];
    assign rd2 = rf_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// -----------------------------------------------------------------------------
// mc_datapath
// Multicycle RV32I datapath driven by the main control FSM. Holds PC, OldPC,
// instruction and data registers, the register file, immediate extender, ALU
// and the A/B/ALUOut pipeline registers; drives a unified memory port.
//
// Ports:
//   Clk, Reset                        clock, asynchronous active-high reset
//   PCWrite, AdrSrc, MemWrite,
//   IRWrite, RegWrite                 per-cycle control strobes
//   ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl                mux / function selects
//   MemAdr, MemWData, MemWE           memory request
//   MemRData                          memory read data (same cycle)
//   op, funct3, funct7b5, Zero        status back to the controller
// -----------------------------------------------------------------------------
module mc_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            PCWrite,
    input  logic            AdrSrc,
    input  logic            MemWrite,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ImmSrc,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] MemAdr,
    output logic [XLEN-1:0] MemWData,
    output logic            MemWE,
    input  logic [XLEN-1:0] MemRData,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic            Zero
);
    import mc_datapath_pkg::*;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] oldpc_reg;
    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] aluout_reg;

    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result;

    // Write address comes from the instruction currently held, so a
    // simultaneous IRWrite never redirects this cycle's writeback.
    mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .Clk   (Clk),
        .Reset (Reset),
        .ra1   (instr_reg[19:15]),
        .ra2   (instr_reg[24:20]),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (RegWrite),
        .wa    (instr_reg[11:7]),
        .wd    (result)
    );

    assign imm_ext = imm_extend(instr_reg, ImmSrc);

    always_comb begin
        case (ALUSrcA)
            SRCA_PC:    src_a = pc_reg;
            SRCA_OLDPC: src_a = oldpc_reg;
            SRCA_A:     src_a = a_reg;
            default:    src_a = '0;
        endcase
    end

    always_comb begin
        case (ALUSrcB)
            SRCB_B:    src_b = b_reg;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = '0;
        endcase
    end

    always_comb begin
        case (ALUControl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        case (ResultSrc)
            RES_ALUOUT: result = aluout_reg;
            RES_DATA:   result = data_reg;
            default:    result = alu_result;
        endcase
    end

    assign MemAdr   = AdrSrc ? result : pc_reg;
    assign MemWData = b_reg;
    assign MemWE    = MemWrite;
    assign op       = instr_reg[6:0];
    assign funct3   = instr_reg[14:12];
    assign funct7b5 = instr_reg[30];
    assign Zero     = (alu_result == '0);

    // A/B/Data/ALUOut are non-architectural and reload every cycle; the
    // controller only samples them in the cycle after they were set up.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_reg     <= RESET_PC;
            oldpc_reg  <= '0;
            instr_reg  <= '0;
            data_reg   <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            aluout_reg <= '0;
        end else begin
            a_reg      <= rf_rd1;
            b_reg      <= rf_rd2;
            data_reg   <= MemRData;
            aluout_reg <= alu_result;
            if (IRWrite) begin
                instr_reg <= MemRData;
                oldpc_reg <= pc_reg;   // pre-update PC, even alongside PCWrite
            end
            if (PCWrite) begin
                pc_reg <= result;
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_mc_datapath
// Table-driven directed sequences for fetch / lw / sw / beq / x0 / reset,
// followed by randomized control and memory data checked against an
// instruction-level reference model of the datapath's architectural rules.
// -----------------------------------------------------------------------------
module tb_mc_datapath;

    logic        Clk;
    logic        Reset;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] MemAdr, MemWData, MemRData;
    logic        MemWE;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero;

    mc_datapath dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .MemAdr     (MemAdr),
        .MemWData   (MemWData),
        .MemWE      (MemWE),
        .MemRData   (MemRData),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       pcw, adrsrc, memw, irw, regw;
        logic [1:0] rsrc, srca, srcb, imms;
        logic [2:0] aluc;
    } ctrl_t;

    typedef struct {
        string       name;
        ctrl_t       c;
        logic [31:0] rdata;
        logic [5:0]  chk;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        we;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        zero;
    } vec_t;

    localparam logic [5:0] C_ADR = 6'd1;
    localparam logic [5:0] C_WD  = 6'd2;
    localparam logic [5:0] C_WE  = 6'd4;
    localparam logic [5:0] C_OP  = 6'd8;
    localparam logic [5:0] C_Z   = 6'd16;
    localparam logic [5:0] C_F3  = 6'd32;

    vec_t tbl[$];

    function automatic ctrl_t mk(bit pcw, bit adrsrc, bit memw, bit irw, bit regw,
                                 bit [1:0] rsrc, bit [1:0] srca, bit [1:0] srcb,
                                 bit [1:0] imms, bit [2:0] aluc);
        ctrl_t c;
        c.pcw = pcw; c.adrsrc = adrsrc; c.memw = memw; c.irw = irw; c.regw = regw;
        c.rsrc = rsrc; c.srca = srca; c.srcb = srcb; c.imms = imms; c.aluc = aluc;
        return c;
    endfunction

    task automatic add(string name, ctrl_t c, logic [31:0] rdata, logic [5:0] chk,
                       logic [31:0] adr, logic [31:0] wdata, logic we,
                       logic [6:0] opc, logic [2:0] f3, logic zero);
        vec_t v;
        v.name = name; v.c = c; v.rdata = rdata; v.chk = chk; v.adr = adr;
        v.wdata = wdata; v.we = we; v.opc = opc; v.f3 = f3; v.zero = zero;
        tbl.push_back(v);
    endtask

    task automatic drive(ctrl_t c, logic [31:0] rdata);
        PCWrite = c.pcw; AdrSrc = c.adrsrc; MemWrite = c.memw; IRWrite = c.irw;
        RegWrite = c.regw; ResultSrc = c.rsrc; ALUSrcA = c.srca; ALUSrcB = c.srcb;
        ImmSrc = c.imms; ALUControl = c.aluc; MemRData = rdata;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each row: drive just after the falling edge, sample 1 ns later, then
    // let the rising edge commit the row's updates.
    task automatic run_table();
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].rdata);
            #1;
            if (tbl[i].chk & C_ADR) check({tbl[i].name, ".MemAdr"},   MemAdr,   tbl[i].adr);
            if (tbl[i].chk & C_WD)  check({tbl[i].name, ".MemWData"}, MemWData, tbl[i].wdata);
            if (tbl[i].chk & C_WE)  check({tbl[i].name, ".MemWE"},    {31'd0, MemWE}, {31'd0, tbl[i].we});
            if (tbl[i].chk & C_OP)  check({tbl[i].name, ".op"},       {25'd0, op},    {25'd0, tbl[i].opc});
            if (tbl[i].chk & C_F3)  check({tbl[i].name, ".funct3"},   {29'd0, funct3}, {29'd0, tbl[i].f3});
            if (tbl[i].chk & C_Z)   check({tbl[i].name, ".Zero"},     {31'd0, Zero},  {31'd0, tbl[i].zero});
            $display("step %-14s MemAdr=%h MemWData=%h MemWE=%b op=%0d Zero=%b",
                     tbl[i].name, MemAdr, MemWData, MemWE, op, Zero);
            @(negedge Clk);
        end
        tbl.delete();
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // ---------------- reference model (architectural rules) ----------------
    bit [31:0] m_pc, m_oldpc, m_instr, m_data, m_a, m_b, m_aluout;
    bit [31:0] m_rf [32];

    task automatic model_reset();
        m_pc = 0; m_oldpc = 0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
        for (int r = 0; r < 32; r++) m_rf[r] = 0;
    endtask

    function automatic bit [31:0] sext(bit [31:0] v, int bits);
        bit [31:0] m;
        m = 32'h1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    function automatic bit [31:0] model_imm(bit [31:0] i, bit [1:0] s);
        case (s)
            2'd0: return sext(i >> 20, 12);
            2'd1: return sext(((i >> 25) << 5) | ((i >> 7) & 32'h1f), 12);
            2'd2: return sext((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                              (((i >> 25) & 32'h3f) << 5) | (((i >> 8) & 32'hf) << 1), 13);
            default: return sext((((i >> 31) & 1) << 20) | (((i >> 12) & 32'hff) << 12) |
                                 (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3ff) << 1), 21);
        endcase
    endfunction

    function automatic bit [31:0] model_alu(bit [31:0] x, bit [31:0] y, bit [2:0] f);
        case (f)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd5: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    ctrl_t NOP, FETCH, WB_IMM, P_A, P_OLDPC, LDIR;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        NOP     = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);
        FETCH   = mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0);
        WB_IMM  = mk(0, 0, 0, 0, 1, 2'd2, 2'd3, 2'd1, 2'd0, 3'd0);
        P_A     = mk(0, 1, 0, 0, 0, 2'd2, 2'd2, 2'd3, 2'd0, 3'd0);
        P_OLDPC = mk(0, 1, 0, 0, 0, 2'd2, 2'd1, 2'd3, 2'd0, 3'd0);
        LDIR    = mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0);

        drive(NOP, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        check("reset.MemAdr", MemAdr, 32'h0);
        check("reset.op", {25'd0, op}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // ---- fetch of lw x6,4(x2) from PC 0 ----
        add("fetch_lw0",   FETCH,   32'h0041_2303, C_ADR,               32'h0, 0, 0, 0, 0, 0);
        add("fetch_pc",    NOP,     32'h0,         C_ADR | C_OP | C_F3, 32'h4, 0, 0, 7'd3, 3'd2, 0);
        add("fetch_oldpc", P_OLDPC, 32'h0,         C_ADR,               32'h0, 0, 0, 0, 0, 0);
        run_table();
        pulse_reset();

        // ---- program: addi x2=0x100, addi x1=0x55, lw, sw, beq, x0 write ----
        add("fetch_x2",   FETCH,  32'h1000_0113, C_ADR, 32'h0, 0, 0, 0, 0, 0);
        add("wb_x2",      WB_IMM, 32'h0,         C_OP,  0, 0, 0, 7'd19, 0, 0);
        add("fetch_x1",   FETCH,  32'h0550_0093, C_ADR, 32'h4, 0, 0, 0, 0, 0);
        add("wb_x1",      WB_IMM, 32'h0,         C_OP,  0, 0, 0, 7'd19, 0, 0);
        add("fetch_lw",   FETCH,  32'h0041_2303, C_ADR, 32'h8, 0, 0, 0, 0, 0);
        add("lw_decode",  NOP,    32'h0,         C_OP | C_F3, 0, 0, 0, 7'd3, 3'd2, 0);
        add("lw_memadr",  mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd0), 32'h0, C_Z, 0, 0, 0, 0, 0, 0);
        add("lw_memread", mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 32'hDEAD_BEEF,
            C_ADR | C_WE, 32'h104, 0, 0, 0, 0, 0);
        add("lw_wb",      mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0), 32'h0, C_ADR, 32'hC, 0, 0, 0, 0, 0);
        add("fetch_sw",   FETCH,  32'h0061_2423, C_ADR | C_WE, 32'hC, 0, 0, 0, 0, 0);
        add("sw_decode",  NOP,    32'h0,         C_OP, 0, 0, 0, 7'd35, 0, 0);
        add("sw_memadr",  mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd1, 3'd0), 32'h0,
            C_WD | C_WE, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add("sw_memwr",   mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 32'h0,
            C_ADR | C_WD | C_WE, 32'h108, 32'hDEAD_BEEF, 1, 0, 0, 0);
        add("fetch_beq",  FETCH,  32'hFE10_8CE3, C_ADR | C_WE, 32'h10, 0, 0, 0, 0, 0);
        add("beq_decode", mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd2, 3'd0), 32'h0, C_OP, 0, 0, 0, 7'd99, 0, 0);
        add("beq_compare", mk(1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 3'd1), 32'h0,
            C_ADR | C_WD | C_Z, 32'h8, 32'h55, 0, 0, 0, 1);
        add("beq_pc",     NOP,    32'h0,         C_ADR, 32'h8, 0, 0, 0, 0, 0);
        add("x0_instr",   LDIR,   32'h0000_0013, 0, 0, 0, 0, 0, 0, 0);
        add("x0_data",    NOP,    32'h0000_1234, 0, 0, 0, 0, 0, 0, 0);
        add("x0_write",   mk(0, 1, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0), 32'h0, C_ADR, 32'h1234, 0, 0, 0, 0, 0);
        add("x0_settle",  NOP,    32'h0,         0, 0, 0, 0, 0, 0, 0);
        add("x0_probe",   P_A,    32'h0,         C_ADR | C_WD | C_Z, 32'h0, 32'h0, 0, 0, 0, 1);
        // ---- set x5 = 0x77 and confirm it through A ----
        add("fetch_x5",   FETCH,  32'h0770_0293, C_ADR, 32'h8, 0, 0, 0, 0, 0);
        add("wb_x5",      WB_IMM, 32'h0,         0, 0, 0, 0, 0, 0, 0);
        add("ld_rs1_x5",  LDIR,   32'h0002_8013, 0, 0, 0, 0, 0, 0, 0);
        add("x5_settle",  NOP,    32'h0,         0, 0, 0, 0, 0, 0, 0);
        add("x5_probe",   P_A,    32'h0,         C_ADR | C_OP, 32'h77, 0, 0, 7'd19, 0, 0);
        run_table();

        // ---- asynchronous reset in the middle of a cycle ----
        drive(mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0), 32'h0);
        #3;
        Reset = 1'b1;
        #1;
        check("midrst.MemAdr", MemAdr, 32'h0);
        check("midrst.op", {25'd0, op}, 32'd0);
        check("midrst.MemWE", {31'd0, MemWE}, 32'd1);
        drive(P_A, 32'h0);
        #1;
        check("midrst.A", MemAdr, 32'h0);
        $display("step midrst        MemAdr=%h op=%0d MemWE=%b", MemAdr, op, MemWE);
        @(negedge Clk);
        Reset = 1'b0;
        add("post_ld_x5", LDIR,  32'h0002_8013, 0, 0, 0, 0, 0, 0, 0);
        add("post_settle", NOP,  32'h0,         0, 0, 0, 0, 0, 0, 0);
        add("post_x5",    P_A,   32'h0,         C_ADR, 32'h0, 0, 0, 0, 0, 0);
        run_table();

        // ---- randomized control against the reference model ----
        pulse_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            ctrl_t     c;
            bit [31:0] rdata, imm, sa, sb, alu, res, exp_adr, new_a, new_b;
            bit        did_reset;
            c     = ctrl_t'($urandom);
            rdata = $urandom;
            drive(c, rdata);
            #1;
            imm = model_imm(m_instr, c.imms);
            sa  = (c.srca == 0) ? m_pc : (c.srca == 1) ? m_oldpc : (c.srca == 2) ? m_a : 32'd0;
            sb  = (c.srcb == 0) ? m_b  : (c.srcb == 1) ? imm     : (c.srcb == 2) ? 32'd4 : 32'd0;
            alu = model_alu(sa, sb, c.aluc);
            res = (c.rsrc == 0) ? m_aluout : (c.rsrc == 1) ? m_data : alu;
            exp_adr = c.adrsrc ? res : m_pc;
            check("rnd.MemAdr", MemAdr, exp_adr);
            check("rnd.MemWData", MemWData, m_b);
            check("rnd.status", {19'd0, MemWE, op, funct3, funct7b5, Zero},
                  {19'd0, c.memw, m_instr[6:0], m_instr[14:12], m_instr[30], alu == 0});
            if (n % 250 == 0)
                $display("rnd %0d ctrl=%h MemAdr=%h op=%0d Zero=%b", n, c, MemAdr, op, Zero);
            did_reset = ($urandom_range(0, 99) == 0);
            if (did_reset) begin
                #2;
                Reset = 1'b1;
                #1;
                check("rnd.reset_op", {25'd0, op}, 32'd0);
            end
            @(negedge Clk);
            if (did_reset) begin
                Reset = 1'b0;
                model_reset();
            end else begin
                new_a = m_rf[m_instr[19:15]];
                new_b = m_rf[m_instr[24:20]];
                if (c.regw && m_instr[11:7] != 0) m_rf[m_instr[11:7]] = res;
                m_a = new_a;
                m_b = new_b;
                m_data = rdata;
                m_aluout = alu;
                if (c.irw) begin
                    m_oldpc = m_pc;
                    m_instr = rdata;
                end
                if (c.pcw) m_pc = res;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
